// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
// Main control FSM for the multi-cycle MIPS datapath. It steps each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath
// select and enable from the current state (Moore). The one exception is PCEn,
// which also depends on Zero.
//
// Ports:
//   clk, rst           rising-edge clock; synchronous active-high reset
//   Op[5:0]            opcode field IR[31:26]
//   Zero               ALU zero flag for the current cycle
//   PCEn               PC write enable = PCWrite | (PCWriteCond & Zero)
//   IorD               memory address select (0 PC, 1 ALUOut)
//   MemRead/MemWrite   memory strobes
//   IRWrite            instruction register load
//   MemtoReg, RegDst   register-file write data / write address selects
//   RegWrite           register-file write enable
//   ALUSrcA, ALUSrcB   ALU operand selects
//   ALUOp              ALU decoder control (00 add, 01 sub, 10 funct)
//   PCSource           next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   State[3:0]         current state code, forced to 0 during reset
// -----------------------------------------------------------------------------
module multi_cycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic       Zero,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] State
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       pc_write;
   logic       pc_write_cond;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Next-state logic; codes 12-15 fall back to FETCH
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (Op == OP_LW)      state_d = S_MEMRD;
            else if (Op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Moore outputs; reset gates everything off in the same cycle
   always_comb begin
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      PCSource      = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      State         = 4'd0;
      if (!rst) begin
         State = state_q;
         case (state_q)
            S_FETCH: begin
               MemRead  = 1'b1;
               IRWrite  = 1'b1;
               ALUSrcB  = 2'b01;
               pc_write = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_ALUWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA       = 1'b1;
               ALUOp         = 2'b01;
               PCSource      = 2'b01;
               pc_write_cond = 1'b1;
            end
            S_JUMP: begin
               PCSource = 2'b10;
               pc_write = 1'b1;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
         endcase
      end
      // Branch enable follows Zero combinationally
      PCEn = pc_write | (pc_write_cond & Zero);
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control
// Self-checking bench for multi_cycle_control. A reference model built from the
// instruction tables (state sequence per opcode, control word per state) is
// compared against the DUT every cycle under randomized Op/Zero stimulus.
// -----------------------------------------------------------------------------
module tb_multi_cycle_control;

   logic       clk;
   logic       rst;
   logic [5:0] Op;
   logic       Zero;
   logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] State;

   int vectors;
   int miscompares;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ILL  = 6'b111111;

   multi_cycle_control dut (
      .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
      .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [18:0] dut_vec;
   assign dut_vec = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State};

   // Expected control word for a state, straight from the per-state table
   function automatic logic [18:0] exp_out(input logic [3:0] st, input logic z);
      logic pcen, iord, mr, mw, irw, m2r, rd, rw, sa;
      logic [1:0] sb, aop, pcs;
      {pcen, iord, mr, mw, irw, m2r, rd, rw, sa} = 9'b0;
      sb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (st)
         4'd0:  begin mr = 1; irw = 1; sb = 2'b01; pcen = 1; end
         4'd1:  sb = 2'b11;
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin mr = 1; iord = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mw = 1; iord = 1; end
         4'd6:  begin sa = 1; aop = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
         4'd9:  begin pcs = 2'b10; pcen = 1; end
         4'd10: begin sa = 1; sb = 2'b10; end
         4'd11: rw = 1;
         default: ;
      endcase
      return {pcen, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, st};
   endfunction

   // Expected state path of one instruction, FETCH inclusive
   task automatic build_seq(input logic [5:0] op, output logic [3:0] s[6], output int n);
      for (int i = 0; i < 6; i++) s[i] = 4'd0;
      s[1] = 4'd1;
      case (op)
         LW:      begin s[2] = 4'd2;  s[3] = 4'd3;  s[4] = 4'd4; n = 5; end
         SW:      begin s[2] = 4'd2;  s[3] = 4'd5;  n = 4; end
         RT:      begin s[2] = 4'd6;  s[3] = 4'd7;  n = 4; end
         ADDI:    begin s[2] = 4'd10; s[3] = 4'd11; n = 4; end
         BEQ:     begin s[2] = 4'd8;  n = 3; end
         JMP:     begin s[2] = 4'd9;  n = 3; end
         default: n = 2;
      endcase
   endtask

   // Runs up to 'limit' cycles of an instruction, checking every cycle.
   // Op is only held meaningful in DECODE/MEMADR; elsewhere it may be scrambled.
   task automatic run_instr(input string name, input logic [5:0] op,
                            input bit force_z, input logic zval,
                            input bit scramble, input int limit);
      logic [3:0] s[6];
      int n;
      logic [18:0] exp;
      build_seq(op, s, n);
      if (limit > 0 && limit < n) n = limit;
      for (int k = 0; k < n; k++) begin
         if (s[k] == 4'd1 || s[k] == 4'd2) Op = op;
         else if (s[k] == 4'd0 || scramble) Op = 6'($urandom);
         else Op = op;
         Zero = (force_z && s[k] == 4'd8) ? zval : 1'($urandom);
         #1;
         exp = exp_out(s[k], Zero);
         vectors++;
         if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h want %h (state got %0d want %0d)",
                     name, k, dut_vec, exp, State, s[k]);
         end
         vectors++;
         if ((MemRead & MemWrite) !== 1'b0 || (RegWrite & MemWrite) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s exclusive strobes step %0d: got rd=%b wr=%b rw=%b want no overlap",
                     name, k, MemRead, MemWrite, RegWrite);
         end
         @(posedge clk); #2;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         Op = 6'($urandom); Zero = 1'($urandom);
         #1;
         vectors++;
         if (dut_vec !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_hold cycle %0d: got %h want %h", c, dut_vec, 19'd0);
         end
         @(posedge clk); #2;
      end
      rst = 1'b0;
      Zero = 1'($urandom);
      #1;
      vectors++;
      if (dut_vec !== exp_out(4'd0, Zero)) begin
         miscompares++;
         $display("FAIL reset_release: got %h want %h", dut_vec, exp_out(4'd0, Zero));
      end
   endtask

   task automatic test_lw();
      run_instr("lw", LW, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_beq();
      run_instr("beq_taken", BEQ, 1'b1, 1'b1, 1'b0, 0);
      run_instr("beq_not_taken", BEQ, 1'b1, 1'b0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      run_instr("rtype", RT, 1'b0, 1'b0, 1'b0, 0);
      run_instr("addi", ADDI, 1'b0, 1'b0, 1'b0, 0);
      run_instr("jump", JMP, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_illegal();
      run_instr("illegal", ILL, 1'b0, 1'b0, 1'b0, 0);
      run_instr("lw_scrambled_op", LW, 1'b0, 1'b0, 1'b1, 0);
   endtask

   task automatic test_random();
      logic [5:0] pool[7];
      logic [5:0] op;
      pool = '{LW, SW, RT, BEQ, JMP, ADDI, ILL};
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = pool[$urandom_range(0, 6)];
         run_instr("random", op, 1'b0, 1'b0, 1'($urandom), 0);
      end
   endtask

   task automatic test_mid_reset();
      run_instr("sw_prefix", SW, 1'b0, 1'b0, 1'b0, 3);
      rst = 1'b1;
      Op = SW; Zero = 1'($urandom);
      #1;
      vectors++;
      if (MemWrite !== 1'b0 || dut_vec !== 19'd0) begin
         miscompares++;
         $display("FAIL mid_reset_gate: got %h MemWrite=%b want %h", dut_vec, MemWrite, 19'd0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      Zero = 1'($urandom);
      #1;
      vectors++;
      if (dut_vec !== exp_out(4'd0, Zero)) begin
         miscompares++;
         $display("FAIL mid_reset_fetch: got %h want %h", dut_vec, exp_out(4'd0, Zero));
      end
      run_instr("after_reset_beq", BEQ, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      Op = 6'd0;
      Zero = 1'b0;
      @(posedge clk); #2;
      test_reset();
      test_lw();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
